// File: rtl/ahb_master.sv
// AHB-Lite single-transfer initiator: one local request becomes one SINGLE/NONSEQ bus transfer.
// Latency: accept at edge 0, address phase cycle 1, data phase cycle 2, rsp_valid cycle 3 (plus wait states).
// Backpressure: req_ready is low while a transfer is in flight; slave waits stretch phases up to TIMEOUT.
module ahb_master #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_error,
    output logic [31:0]       rsp_rdata,
    output logic              hsel,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic [1:0]        hsize,
    output logic              hwrite,
    output logic [31:0]       hwdata,
    input  logic [31:0]       hrdata,
    input  logic              hready,
    input  logic              hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [8:0] TIMEOUT_CNT   = 9'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t state_q, state_d;

    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              req_ready_d, rsp_valid_d, rsp_error_d;
    logic [31:0]       rsp_rdata_d;
    logic              hsel_d, hwrite_d;
    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d, hsize_d;
    logic [31:0]       hwdata_d;

    logic        accept, req_illegal, timeout_hit, done, bus_err;
    logic [8:0]  wait_next;
    logic [31:0] rdata_ext;

    // Only SINGLE bursts are ever issued.
    assign hburst = 3'b000;

    // Request classification and data-phase completion terms.
    always_comb begin
        accept      = req_valid && req_ready;
        req_illegal = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        wait_next   = {1'b0, wait_cnt_q} + 9'd1;
        // The wait edge that would bring the counter to TIMEOUT ends the transfer with an error.
        timeout_hit = !hready && !hresp && (wait_next >= TIMEOUT_CNT);
        done        = hready || hresp || timeout_hit;
        bus_err     = hresp || timeout_hit;
    end

    // Narrow reads are zero-extended from the low lanes of hrdata.
    always_comb begin
        case (hsize)
            2'd0:    rdata_ext = {24'b0, hrdata[7:0]};
            2'd1:    rdata_ext = {16'b0, hrdata[15:0]};
            default: rdata_ext = hrdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !req_illegal) state_d = S_ADDR;
            S_ADDR:  if (hready) state_d = S_DATA;
            S_DATA:  if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; fields hold unless a transition updates them.
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = 1'b0;
        rsp_error_d = rsp_error;
        rsp_rdata_d = rsp_rdata;
        hsel_d      = hsel;
        haddr_d     = haddr;
        htrans_d    = htrans;
        hsize_d     = hsize;
        hwrite_d    = hwrite;
        hwdata_d    = hwdata;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_illegal) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'b0;
                    end else begin
                        haddr_d  = req_addr;
                        hsize_d  = req_size;
                        hwrite_d = req_write;
                        wdata_d  = req_wdata;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                    end
                end
            end
            S_ADDR: begin
                if (hready) begin
                    hsel_d     = 1'b0;
                    htrans_d   = HTRANS_IDLE;
                    hwdata_d   = hwrite ? wdata_q : 32'b0;
                    wait_cnt_d = 8'd0;
                end
            end
            S_DATA: begin
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus_err;
                    rsp_rdata_d = (bus_err || hwrite) ? 32'b0 : rdata_ext;
                    hwdata_d    = 32'b0;
                end else if (wait_cnt_q != 8'hFF) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_rdata  <= 32'b0;
            hsel       <= 1'b0;
            haddr      <= '0;
            htrans     <= HTRANS_IDLE;
            hsize      <= 2'd0;
            hwrite     <= 1'b0;
            hwdata     <= 32'b0;
            wdata_q    <= 32'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            req_ready  <= req_ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_error  <= rsp_error_d;
            rsp_rdata  <= rsp_rdata_d;
            hsel       <= hsel_d;
            haddr      <= haddr_d;
            htrans     <= htrans_d;
            hsize      <= hsize_d;
            hwrite     <= hwrite_d;
            hwdata     <= hwdata_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed vector table, hand-written reset sequences, random transfers.
// Slave timing is scripted per cycle relative to the accept edge; outputs sampled on negedge.
// Request inputs are driven with garbage while the master is busy to confirm they are ignored.
module tb_ahb_master;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_error;
    logic [31:0]       rsp_rdata;
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [1:0]        hsize;
    logic              hwrite;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic              hready;
    logic              hresp;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hburst(hburst),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // One transfer: request fields, slave script (address waits, data waits,
    // error flag and hready value on the error edge, read data) and expected response.
    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [1:0]  sz;
        logic [31:0] wd;
        int          aw;
        int          dw;
        bit          serr;
        bit          erdy;
        logic [31:0] rd;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " hsel"}, 32'(hsel), 32'd0);
        chk({tag, " haddr"}, 32'(haddr), 32'd0);
        chk({tag, " htrans"}, 32'(htrans), 32'd0);
        chk({tag, " hsize"}, 32'(hsize), 32'd0);
        chk({tag, " hwrite"}, 32'(hwrite), 32'd0);
        chk({tag, " hwdata"}, hwdata, 32'd0);
        chk({tag, " hburst"}, 32'(hburst), 32'd0);
    endtask

    function automatic bit is_illegal(input logic [3:0] addr, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    endfunction

    // Reference model: expected completion status and data from the transfer rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        longint mask;
        if (is_illegal(v.addr, v.sz)) begin
            r.exp_err = 1'b1;
        end else if (v.dw >= TIMEOUT) begin
            r.exp_err = 1'b1;
        end else begin
            r.exp_err = v.serr;
        end
        mask = (64'd1 << (8 << v.sz)) - 1;
        r.exp_rd = (r.exp_err || v.wr) ? 32'd0 : 32'(longint'(v.rd) & mask);
        return r;
    endfunction

    // Entered and left just after a negedge.
    task automatic run_txn(input vec_t v);
        int nd;
        logic [31:0] rd_hold;
        chk("pre req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_size  = v.sz;
        req_wdata = v.wd;
        hready    = 1'b1;
        hresp     = 1'b0;
        @(negedge clk);
        if (is_illegal(v.addr, v.sz)) begin
            chk("ill rsp_valid", 32'(rsp_valid), 32'd1);
            chk("ill rsp_error", 32'(rsp_error), 32'd1);
            chk("ill rsp_rdata", rsp_rdata, 32'd0);
            chk("ill htrans", 32'(htrans), 32'd0);
            chk("ill hsel", 32'(hsel), 32'd0);
            chk("ill req_ready", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            @(negedge clk);
            chk("ill rsp_valid drop", 32'(rsp_valid), 32'd0);
            chk("ill htrans after", 32'(htrans), 32'd0);
            return;
        end
        // Busy: present an illegal request that must be ignored.
        req_valid = 1'b1;
        req_size  = 2'd3;
        req_addr  = 4'($urandom);
        req_wdata = $urandom;
        for (int i = 0; i <= v.aw; i++) begin
            chk("addr htrans", 32'(htrans), 32'd2);
            chk("addr hsel", 32'(hsel), 32'd1);
            chk("addr haddr", 32'(haddr), 32'(v.addr));
            chk("addr hsize", 32'(hsize), 32'(v.sz));
            chk("addr hwrite", 32'(hwrite), 32'(v.wr));
            chk("addr req_ready", 32'(req_ready), 32'd0);
            chk("addr rsp_valid", 32'(rsp_valid), 32'd0);
            hready = (i == v.aw);
            hresp  = 1'b0;
            hrdata = $urandom;
            @(negedge clk);
        end
        nd = (v.dw >= TIMEOUT) ? TIMEOUT : v.dw + 1;
        for (int j = 0; j < nd; j++) begin
            chk("data htrans", 32'(htrans), 32'd0);
            chk("data hsel", 32'(hsel), 32'd0);
            chk("data hwdata", hwdata, v.wr ? v.wd : 32'd0);
            chk("data req_ready", 32'(req_ready), 32'd0);
            chk("data rsp_valid", 32'(rsp_valid), 32'd0);
            if (j == v.dw) begin
                hresp  = v.serr;
                hready = v.serr ? v.erdy : 1'b1;
                hrdata = v.rd;
            end else begin
                hresp  = 1'b0;
                hready = 1'b0;
                hrdata = $urandom;
            end
            @(negedge clk);
        end
        chk("rsp rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp rsp_error", 32'(rsp_error), 32'(v.exp_err));
        chk("rsp rsp_rdata", rsp_rdata, v.exp_rd);
        chk("rsp req_ready", 32'(req_ready), 32'd1);
        chk("rsp htrans", 32'(htrans), 32'd0);
        rd_hold   = rsp_rdata;
        req_valid = 1'b0;
        hready    = 1'b1;
        hresp     = 1'b0;
        hrdata    = $urandom;
        @(negedge clk);
        chk("post rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post rsp_error hold", 32'(rsp_error), 32'(v.exp_err));
        chk("post rsp_rdata hold", rsp_rdata, rd_hold);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        // wr addr sz wd aw dw serr erdy rd exp_err exp_rd
        vecs.push_back('{1, 4'hC, 2'd0, 32'h03, 0, 0, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 4'h8, 2'd0, 32'h0, 0, 2, 0, 0, 32'hABCD1234, 0, 32'h34});
        vecs.push_back('{1, 4'h4, 2'd0, 32'h5A, 0, 1, 1, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 4'h4, 2'd2, 32'h0, 1, 0, 1, 1, 32'hFFFFFFFF, 1, 32'h0});
        vecs.push_back('{0, 4'h0, 2'd3, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{1, 4'h2, 2'd2, 32'h77, 0, 0, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 4'h1, 2'd1, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 4'h4, 2'd2, 32'h0, 0, 16, 0, 0, 32'h12345678, 1, 32'h0});
        vecs.push_back('{0, 4'h2, 2'd1, 32'h0, 0, 15, 0, 0, 32'h11223344, 0, 32'h3344});
        vecs.push_back('{1, 4'h8, 2'd2, 32'hCAFEF00D, 0, 100, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 4'h6, 2'd1, 32'h0, 2, 1, 0, 0, 32'h1234BEEF, 0, 32'hBEEF});
        vecs.push_back('{1, 4'hE, 2'd1, 32'hA5A5_5A5A, 3, 3, 0, 0, 32'h0, 0, 32'h0});

        n_rst     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = 2'd0;
        req_wdata = 32'd0;
        hrdata    = 32'd0;
        hready    = 1'b1;
        hresp     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        n_rst = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) run_txn(vecs[k]);

        // Reset during an address phase that the slave is stalling.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h8;
        req_size  = 2'd2;
        req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("mid htrans before reset", 32'(htrans), 32'd2);
        req_valid = 1'b0;
        hready    = 1'b0;
        n_rst     = 1'b0;
        @(negedge clk);
        check_reset_vals("mid reset");
        n_rst  = 1'b1;
        hready = 1'b1;
        @(negedge clk);
        chk("mid no rsp", 32'(rsp_valid), 32'd0);
        chk("mid htrans idle", 32'(htrans), 32'd0);
        v = '{0, 4'h0, 2'd2, 32'h0, 0, 0, 0, 0, 32'h89ABCDEF, 0, 32'h0};
        v.exp_rd = 32'h89ABCDEF;
        run_txn(v);

        // Random transfers checked against the reference model.
        for (int n = 0; n < 60; n++) begin
            v.wr   = 1'($urandom);
            v.sz   = 2'($urandom);
            v.addr = 4'($urandom);
            if ($urandom_range(0, 3) != 0 && v.sz != 2'd3)
                v.addr = 4'(v.addr & ~((4'd1 << v.sz) - 4'd1));
            v.wd   = $urandom;
            v.aw   = $urandom_range(0, 2);
            v.dw   = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 4);
            v.serr = ($urandom_range(0, 4) == 0);
            v.erdy = 1'($urandom);
            v.rd   = $urandom;
            run_txn(model(v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
